// File: rtl/zeroriscy_defines.sv
// Shared constants and enums for the zero-riscy trap sequencer:
// PC mux selectors, exception vector selectors, mcause codes, FSM state and trap kind.
package zeroriscy_defines;

  localparam logic [2:0] PC_BOOT      = 3'b000;
  localparam logic [2:0] PC_EXCEPTION = 3'b100;
  localparam logic [2:0] PC_ERET      = 3'b101;

  localparam logic [1:0] EXC_PC_ILLINSN = 2'b00;
  localparam logic [1:0] EXC_PC_ECALL   = 2'b01;
  localparam logic [1:0] EXC_PC_IRQ     = 2'b11;

  localparam logic [5:0] EXC_CAUSE_NONE         = 6'h00;
  localparam logic [5:0] EXC_CAUSE_ILLEGAL_INSN = 6'h02;
  localparam logic [5:0] EXC_CAUSE_BREAKPOINT   = 6'h03;
  localparam logic [5:0] EXC_CAUSE_ECALL_MMODE  = 6'h0B;

  typedef enum logic [1:0] {
    ST_DECODE = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_TRAP   = 2'd2,
    ST_RET    = 2'd3
  } trap_state_e;

  // The exception flavour is folded into the kind so TRAP can pick cause/vector directly.
  typedef enum logic [2:0] {
    KIND_NONE    = 3'd0,
    KIND_ILLEGAL = 3'd1,
    KIND_ECALL   = 3'd2,
    KIND_EBREAK  = 3'd3,
    KIND_MRET    = 3'd4,
    KIND_IRQ     = 3'd5
  } trap_kind_e;

  function automatic logic [5:0] irq_cause(input logic [4:0] id);
    return {1'b1, id};
  endfunction

endpackage

// File: rtl/zeroriscy_int_controller.sv
// Interrupt qualifier: gates irq_i with mstatus.MIE, holds the captured line id
// and drives the acknowledge pulse while the trap FSM is in TRAP for an IRQ.
module zeroriscy_int_controller
  import zeroriscy_defines::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       irq_i,
  input  logic [4:0] irq_id_i,
  input  logic       m_irq_enable_i,
  input  logic       capture_i,
  input  logic       ack_i,
  output logic       irq_req_o,
  output logic [4:0] irq_id_q_o,
  output logic       irq_ack_o,
  output logic [4:0] irq_id_o
);

  logic [4:0] irq_id_q;
  logic [4:0] irq_id_d;

  assign irq_req_o = irq_i & m_irq_enable_i;

  // The id is latched at detection so a request dropped during FLUSH is still served.
  always_comb begin
    irq_id_d = irq_id_q;
    if (capture_i) begin
      irq_id_d = irq_id_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_id_q <= 5'd0;
    end else begin
      irq_id_q <= irq_id_d;
    end
  end

  assign irq_id_q_o = irq_id_q;
  assign irq_ack_o  = ack_i;
  assign irq_id_o   = ack_i ? irq_id_q : 5'd0;

endmodule

// File: rtl/zeroriscy_trap_ctrl.sv
// Trap sequencer: detects exceptions, MRET and enabled interrupts in ID, stalls
// until the LSU drains, then issues one-cycle CSR save/restore strobes and PC controls.
module zeroriscy_trap_ctrl
  import zeroriscy_defines::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       irq_i,
  input  logic [4:0] irq_id_i,
  input  logic       m_irq_enable_i,
  input  logic       instr_valid_i,
  input  logic       illegal_insn_i,
  input  logic       ecall_insn_i,
  input  logic       ebrk_insn_i,
  input  logic       mret_insn_i,
  input  logic       lsu_busy_i,
  output logic       halt_id_o,
  output logic       pc_set_o,
  output logic [2:0] pc_mux_o,
  output logic [1:0] exc_pc_mux_o,
  output logic [4:0] exc_vec_pc_mux_o,
  output logic       csr_save_cause_o,
  output logic       csr_save_if_o,
  output logic       csr_save_id_o,
  output logic       csr_restore_mret_o,
  output logic [5:0] csr_cause_o,
  output logic       irq_ack_o,
  output logic [4:0] irq_id_o
);

  trap_state_e state_q, state_d;
  trap_kind_e  kind_q, kind_d;

  logic       irq_req;
  logic [4:0] irq_id_q;
  logic       irq_capture;
  logic       irq_ack_req;
  logic       exc_detect;
  logic       mret_detect;

  assign exc_detect  = instr_valid_i & (illegal_insn_i | ecall_insn_i | ebrk_insn_i);
  assign mret_detect = instr_valid_i & mret_insn_i;
  assign irq_capture = (state_q == ST_DECODE) & ~exc_detect & ~mret_detect & irq_req;
  assign irq_ack_req = (state_q == ST_TRAP) & (kind_q == KIND_IRQ);

  zeroriscy_int_controller u_int_controller (
    .clk            (clk),
    .rst_n          (rst_n),
    .irq_i          (irq_i),
    .irq_id_i       (irq_id_i),
    .m_irq_enable_i (m_irq_enable_i),
    .capture_i      (irq_capture),
    .ack_i          (irq_ack_req),
    .irq_req_o      (irq_req),
    .irq_id_q_o     (irq_id_q),
    .irq_ack_o      (irq_ack_o),
    .irq_id_o       (irq_id_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_DECODE;
      kind_q  <= KIND_NONE;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    kind_d             = kind_q;
    halt_id_o          = 1'b0;
    pc_set_o           = 1'b0;
    pc_mux_o           = PC_BOOT;
    exc_pc_mux_o       = EXC_PC_ILLINSN;
    exc_vec_pc_mux_o   = 5'd0;
    csr_save_cause_o   = 1'b0;
    csr_save_if_o      = 1'b0;
    csr_save_id_o      = 1'b0;
    csr_restore_mret_o = 1'b0;
    csr_cause_o        = EXC_CAUSE_NONE;

    unique case (state_q)
      ST_DECODE: begin
        if (exc_detect) begin
          halt_id_o = 1'b1;
          state_d   = ST_FLUSH;
          if (illegal_insn_i)    kind_d = KIND_ILLEGAL;
          else if (ecall_insn_i) kind_d = KIND_ECALL;
          else                   kind_d = KIND_EBREAK;
        end else if (mret_detect) begin
          halt_id_o = 1'b1;
          state_d   = ST_FLUSH;
          kind_d    = KIND_MRET;
        end else if (irq_req) begin
          halt_id_o = 1'b1;
          state_d   = ST_FLUSH;
          kind_d    = KIND_IRQ;
        end
      end

      ST_FLUSH: begin
        halt_id_o = 1'b1;
        if (!lsu_busy_i) begin
          state_d = (kind_q == KIND_MRET) ? ST_RET : ST_TRAP;
        end
      end

      ST_TRAP: begin
        halt_id_o        = 1'b1;
        pc_set_o         = 1'b1;
        pc_mux_o         = PC_EXCEPTION;
        csr_save_cause_o = 1'b1;
        state_d          = ST_DECODE;
        if (kind_q == KIND_IRQ) begin
          csr_save_if_o    = 1'b1;
          csr_cause_o      = irq_cause(irq_id_q);
          exc_pc_mux_o     = EXC_PC_IRQ;
          exc_vec_pc_mux_o = irq_id_q;
        end else begin
          csr_save_id_o = 1'b1;
          // Ebreak shares the illegal-instruction vector.
          unique case (kind_q)
            KIND_ECALL: begin
              csr_cause_o  = EXC_CAUSE_ECALL_MMODE;
              exc_pc_mux_o = EXC_PC_ECALL;
            end
            KIND_EBREAK: begin
              csr_cause_o  = EXC_CAUSE_BREAKPOINT;
              exc_pc_mux_o = EXC_PC_ILLINSN;
            end
            default: begin
              csr_cause_o  = EXC_CAUSE_ILLEGAL_INSN;
              exc_pc_mux_o = EXC_PC_ILLINSN;
            end
          endcase
        end
      end

      ST_RET: begin
        halt_id_o          = 1'b1;
        pc_set_o           = 1'b1;
        pc_mux_o           = PC_ERET;
        csr_restore_mret_o = 1'b1;
        state_d            = ST_DECODE;
      end

      default: begin
        state_d = ST_DECODE;
      end
    endcase
  end

endmodule

// File: tb/tb_zeroriscy_trap_ctrl.sv
// Directed bench for zeroriscy_trap_ctrl: a per-cycle vector table plus hand-written
// sequences for LSU-stall latency and reset during FLUSH.
module tb_zeroriscy_trap_ctrl;

  logic       clk;
  logic       rst_n;
  logic       irq_i;
  logic [4:0] irq_id_i;
  logic       m_irq_enable_i;
  logic       instr_valid_i;
  logic       illegal_insn_i;
  logic       ecall_insn_i;
  logic       ebrk_insn_i;
  logic       mret_insn_i;
  logic       lsu_busy_i;
  logic       halt_id_o;
  logic       pc_set_o;
  logic [2:0] pc_mux_o;
  logic [1:0] exc_pc_mux_o;
  logic [4:0] exc_vec_pc_mux_o;
  logic       csr_save_cause_o;
  logic       csr_save_if_o;
  logic       csr_save_id_o;
  logic       csr_restore_mret_o;
  logic [5:0] csr_cause_o;
  logic       irq_ack_o;
  logic [4:0] irq_id_o;

  zeroriscy_trap_ctrl dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .irq_i              (irq_i),
    .irq_id_i           (irq_id_i),
    .m_irq_enable_i     (m_irq_enable_i),
    .instr_valid_i      (instr_valid_i),
    .illegal_insn_i     (illegal_insn_i),
    .ecall_insn_i       (ecall_insn_i),
    .ebrk_insn_i        (ebrk_insn_i),
    .mret_insn_i        (mret_insn_i),
    .lsu_busy_i         (lsu_busy_i),
    .halt_id_o          (halt_id_o),
    .pc_set_o           (pc_set_o),
    .pc_mux_o           (pc_mux_o),
    .exc_pc_mux_o       (exc_pc_mux_o),
    .exc_vec_pc_mux_o   (exc_vec_pc_mux_o),
    .csr_save_cause_o   (csr_save_cause_o),
    .csr_save_if_o      (csr_save_if_o),
    .csr_save_id_o      (csr_save_id_o),
    .csr_restore_mret_o (csr_restore_mret_o),
    .csr_cause_o        (csr_cause_o),
    .irq_ack_o          (irq_ack_o),
    .irq_id_o           (irq_id_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       irq;
    logic [4:0] irq_id;
    logic       mie;
    logic       valid;
    logic       ill;
    logic       ecall;
    logic       ebrk;
    logic       mret;
    logic       busy;
  } in_t;

  // halt, pc_set, pc_mux, exc_pc, vec, save_cause, save_if, save_id, restore, cause, ack, ack_id
  typedef struct packed {
    logic       halt;
    logic       pc_set;
    logic [2:0] pc_mux;
    logic [1:0] exc_pc;
    logic [4:0] vec;
    logic       save_cause;
    logic       save_if;
    logic       save_id;
    logic       restore;
    logic [5:0] cause;
    logic       ack;
    logic [4:0] ack_id;
  } out_t;

  typedef struct packed {
    in_t  in;
    out_t exp;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic in_t mk_in(logic irq, logic [4:0] id, logic mie, logic valid,
                                logic ill, logic ecall, logic ebrk, logic mret, logic busy);
    in_t r;
    r = '{irq, id, mie, valid, ill, ecall, ebrk, mret, busy};
    return r;
  endfunction

  function automatic out_t o_zero();
    out_t r;
    r = '0;
    return r;
  endfunction

  function automatic out_t o_halt();
    out_t r;
    r = '0;
    r.halt = 1'b1;
    return r;
  endfunction

  function automatic out_t o_exc(logic [5:0] cause, logic [1:0] exc_pc);
    out_t r;
    r = '0;
    r.halt = 1'b1; r.pc_set = 1'b1; r.pc_mux = 3'b100;
    r.save_cause = 1'b1; r.save_id = 1'b1;
    r.cause = cause; r.exc_pc = exc_pc;
    return r;
  endfunction

  function automatic out_t o_irq(logic [4:0] id);
    out_t r;
    r = '0;
    r.halt = 1'b1; r.pc_set = 1'b1; r.pc_mux = 3'b100;
    r.save_cause = 1'b1; r.save_if = 1'b1;
    r.cause = {1'b1, id}; r.exc_pc = 2'b11; r.vec = id;
    r.ack = 1'b1; r.ack_id = id;
    return r;
  endfunction

  function automatic out_t o_ret();
    out_t r;
    r = '0;
    r.halt = 1'b1; r.pc_set = 1'b1; r.pc_mux = 3'b101; r.restore = 1'b1;
    return r;
  endfunction

  function automatic out_t sample();
    out_t r;
    r = '{halt_id_o, pc_set_o, pc_mux_o, exc_pc_mux_o, exc_vec_pc_mux_o,
          csr_save_cause_o, csr_save_if_o, csr_save_id_o, csr_restore_mret_o,
          csr_cause_o, irq_ack_o, irq_id_o};
    return r;
  endfunction

  task automatic drive(input in_t v);
    irq_i          = v.irq;
    irq_id_i       = v.irq_id;
    m_irq_enable_i = v.mie;
    instr_valid_i  = v.valid;
    illegal_insn_i = v.ill;
    ecall_insn_i   = v.ecall;
    ebrk_insn_i    = v.ebrk;
    mret_insn_i    = v.mret;
    lsu_busy_i     = v.busy;
  endtask

  task automatic check_out(input string name, input out_t exp);
    out_t act;
    act = sample();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end else begin
      $display("pass %s: out %h", name, act);
    end
  endtask

  task automatic add(input in_t i, input out_t e);
    tbl.push_back('{i, e});
  endtask

  initial begin
    in_t  idle;
    out_t e;
    int   lat;
    bit   found;
    string nm;

    idle = mk_in(0, 5'd0, 0, 0, 0, 0, 0, 0, 0);

    // Illegal, LSU idle: halt in cycles 0-2, TRAP in cycle 2.
    add(mk_in(0, 0, 0, 1, 1, 0, 0, 0, 0), o_halt());
    add(idle, o_halt());
    add(idle, o_exc(6'h02, 2'b00));
    add(idle, o_zero());
    // ECALL, LSU busy for 3 FLUSH cycles: TRAP in cycle 5.
    add(mk_in(0, 0, 0, 1, 0, 1, 0, 0, 0), o_halt());
    add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1), o_halt());
    add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1), o_halt());
    add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1), o_halt());
    add(idle, o_halt());
    add(idle, o_exc(6'h0B, 2'b01));
    // Ebreak plus ecall: ecall wins. Then ebreak alone.
    add(mk_in(0, 0, 0, 1, 0, 1, 1, 0, 0), o_halt());
    add(idle, o_halt());
    add(idle, o_exc(6'h0B, 2'b01));
    add(mk_in(0, 0, 0, 1, 0, 0, 1, 0, 0), o_halt());
    add(idle, o_halt());
    add(idle, o_exc(6'h03, 2'b00));
    // All three flags: illegal wins. Unqualified flags are ignored.
    add(mk_in(0, 0, 0, 1, 1, 1, 1, 1, 0), o_halt());
    add(idle, o_halt());
    add(idle, o_exc(6'h02, 2'b00));
    add(mk_in(0, 0, 0, 0, 1, 1, 1, 1, 0), o_zero());
    // IRQ id 7 with MIE; then MIE cleared so no re-entry.
    add(mk_in(1, 5'd7, 1, 0, 0, 0, 0, 0, 0), o_halt());
    add(mk_in(1, 5'd7, 1, 0, 0, 0, 0, 0, 0), o_halt());
    add(mk_in(1, 5'd7, 1, 0, 0, 0, 0, 0, 0), o_irq(5'd7));
    add(mk_in(1, 5'd7, 0, 0, 0, 0, 0, 0, 0), o_zero());
    add(mk_in(1, 5'd7, 0, 0, 0, 0, 0, 0, 0), o_zero());
    // IRQ dropped during FLUSH is still taken with the captured id.
    add(mk_in(1, 5'd3, 1, 0, 0, 0, 0, 0, 0), o_halt());
    add(mk_in(0, 5'd9, 1, 0, 0, 0, 0, 0, 0), o_halt());
    add(mk_in(0, 5'd9, 0, 0, 0, 0, 0, 0, 0), o_irq(5'd3));
    // Illegal + IRQ together: exception first, IRQ after MRET restores MIE.
    add(mk_in(1, 5'd5, 1, 1, 1, 0, 0, 0, 0), o_halt());
    add(mk_in(1, 5'd5, 1, 0, 0, 0, 0, 0, 0), o_halt());
    add(mk_in(1, 5'd5, 1, 0, 0, 0, 0, 0, 0), o_exc(6'h02, 2'b00));
    add(mk_in(1, 5'd5, 0, 0, 0, 0, 0, 0, 0), o_zero());
    add(mk_in(1, 5'd5, 0, 1, 0, 0, 0, 1, 0), o_halt());
    add(mk_in(1, 5'd5, 0, 0, 0, 0, 0, 0, 0), o_halt());
    add(mk_in(1, 5'd5, 0, 0, 0, 0, 0, 0, 0), o_ret());
    add(mk_in(1, 5'd5, 1, 0, 0, 0, 0, 0, 0), o_halt());
    add(mk_in(1, 5'd5, 1, 0, 0, 0, 0, 0, 0), o_halt());
    add(mk_in(1, 5'd5, 1, 0, 0, 0, 0, 0, 0), o_irq(5'd5));
    add(mk_in(1, 5'd5, 0, 0, 0, 0, 0, 0, 0), o_zero());
    // MRET and IRQ together with MIE set: MRET wins, IRQ right after RET.
    add(mk_in(1, 5'd17, 1, 1, 0, 0, 0, 1, 0), o_halt());
    add(mk_in(1, 5'd17, 1, 0, 0, 0, 0, 0, 0), o_halt());
    add(mk_in(1, 5'd17, 1, 0, 0, 0, 0, 0, 0), o_ret());
    add(mk_in(1, 5'd17, 1, 0, 0, 0, 0, 0, 0), o_halt());
    add(mk_in(0, 5'd0, 1, 0, 0, 0, 0, 0, 0), o_halt());
    add(mk_in(0, 5'd0, 1, 0, 0, 0, 0, 0, 0), o_irq(5'd17));
    add(idle, o_zero());

    drive(idle);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_out("reset_state", o_zero());
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1 drive(tbl[i].in);
      @(negedge clk);
      nm = $sformatf("vec%0d", i);
      check_out(nm, tbl[i].exp);
    end

    // MRET with LSU busy for two FLUSH cycles: RET expected in cycle 4.
    @(posedge clk);
    #1;
    found = 1'b0;
    lat   = -1;
    for (int c = 0; c < 20; c++) begin
      drive(mk_in(0, 0, 0, c == 0, 0, 0, 0, c == 0, (c == 1) || (c == 2)));
      @(negedge clk);
      if (pc_set_o) begin
        found = 1'b1;
        lat   = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (!found || lat != 4) begin
      errors++;
      $display("FAIL mret_latency: got %0d required 4", lat);
    end else begin
      $display("pass mret_latency: %0d", lat);
    end
    check_out("mret_ret_outputs", o_ret());

    // Reset asserted in FLUSH: back to DECODE, no strobe afterwards.
    @(posedge clk);
    #1 drive(mk_in(0, 0, 0, 1, 1, 0, 0, 0, 0));
    @(posedge clk);
    #1 drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1));
    @(negedge clk);
    check_out("flush_before_reset", o_halt());
    #1 rst_n = 1'b0;
    #1 drive(idle);
    #1 check_out("reset_in_flush", o_zero());
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      nm = $sformatf("post_reset%0d", c);
      check_out(nm, o_zero());
      @(posedge clk);
      #1;
    end

    // After reset the sequencer must accept a fresh IRQ normally.
    drive(mk_in(1, 5'd31, 1, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(negedge clk);
    e = o_irq(5'd31);
    check_out("irq_after_reset", e);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
